// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - Parallel word to MSB-first bit stream feeder for serial divisibility FSMs
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             ser_rst,
    output logic             ser_bit,
    output logic             ser_active,
    output logic             result_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             take;

    // in_ready depends only on state, so the handshake has no path back from in_valid
    assign in_ready = (state == S_IDLE) || (state == S_DONE);
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (take) begin
                        shreg <= in_data;
                    end
                end
                S_CLEAR: begin
                    cnt <= flush ? '0 : CW'(WIDTH);
                end
                S_SHIFT: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        shreg <= shreg << 1;
                        cnt   <= cnt - CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        ser_rst      = 1'b0;
        ser_bit      = 1'b0;
        ser_active   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ser_rst    = 1'b1;
                busy       = 1'b1;
                state_next = flush ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                ser_bit    = shreg[WIDTH-1];
                ser_active = 1'b1;
                busy       = 1'b1;
                if (flush) begin
                    state_next = S_IDLE;
                end else if (cnt == CW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_next   = take ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// tb/tb_serial_word_feeder.sv - Self-checking bench for serial_word_feeder with a timeline model
module tb_serial_word_feeder;

    localparam int W = 8;
    localparam int N = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         flush = 1'b0;
    logic         in_ready, ser_rst, ser_bit, ser_active, result_valid, busy;

    logic         in_valid1 = 1'b0;
    logic [0:0]   in_data1 = 1'b0;
    logic         in_ready1, ser_rst1, ser_bit1, ser_active1, result_valid1, busy1;

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .ser_rst(ser_rst), .ser_bit(ser_bit),
        .ser_active(ser_active), .result_valid(result_valid), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .flush(1'b0), .ser_rst(ser_rst1), .ser_bit(ser_bit1),
        .ser_active(ser_active1), .result_valid(result_valid1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_end = -1;
    bit model_on = 1'b0;

    // Expected per-cycle timeline, filled in when the model decides a word was accepted
    bit exp_rst [0:N-1];
    bit exp_bit [0:N-1];
    bit exp_act [0:N-1];
    bit exp_rv  [0:N-1];
    int exp_word[0:N-1];

    bit h_ready[0:N-1], h_busy[0:N-1], h_rst[0:N-1], h_bit[0:N-1], h_rv[0:N-1];
    bit h_d3[0:N-1], h_d5[0:N-1];
    bit h1_rst[0:N-1], h1_bit[0:N-1], h1_rv[0:N-1], h1_d3[0:N-1];

    int r3 = 0, r5 = 0, r13 = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic cancel_after(input int c);
        for (int k = c + 1; k <= c + W + 2 && k < N; k++) begin
            exp_rst[k] = 1'b0; exp_bit[k] = 1'b0; exp_act[k] = 1'b0; exp_rv[k] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            exp_rst[k] = 1'b0; exp_bit[k] = 1'b0; exp_act[k] = 1'b0; exp_rv[k] = 1'b0;
            exp_word[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            cancel_after(cyc);
            busy_end = cyc;
        end else if (flush && !(cyc > busy_end)) begin
            cancel_after(cyc);
            busy_end = cyc;
        end else if (in_valid && (cyc > busy_end)) begin
            exp_rst[cyc + 1] = 1'b1;
            for (int i = 0; i < W; i++) begin
                exp_bit[cyc + 2 + i] = in_data[W - 1 - i];
                exp_act[cyc + 2 + i] = 1'b1;
            end
            exp_rv[cyc + W + 2]   = 1'b1;
            exp_word[cyc + W + 2] = int'(in_data);
            busy_end = cyc + W + 1;
        end
        cyc = cyc + 1;
    end

    // Downstream divisibility FSMs are modelled as running residues of the bit stream
    always @(negedge clk) begin
        if (model_on) begin
            chk("in_ready", int'(in_ready), int'(cyc > busy_end));
            chk("busy", int'(busy), int'(!(cyc > busy_end)));
            chk("ser_rst", int'(ser_rst), int'(exp_rst[cyc]));
            chk("ser_bit", int'(ser_bit), int'(exp_bit[cyc]));
            chk("ser_active", int'(ser_active), int'(exp_act[cyc]));
            chk("result_valid", int'(result_valid), int'(exp_rv[cyc]));
            if (exp_rv[cyc]) begin
                chk("div_by_3", int'(r3 == 0), int'(exp_word[cyc] % 3 == 0));
                chk("div_by_5", int'(r5 == 0), int'(exp_word[cyc] % 5 == 0));
            end
        end
        h_ready[cyc] = in_ready; h_busy[cyc] = busy; h_rst[cyc] = ser_rst;
        h_bit[cyc] = ser_bit; h_rv[cyc] = result_valid;
        h_d3[cyc] = (r3 == 0); h_d5[cyc] = (r5 == 0);
        h1_rst[cyc] = ser_rst1; h1_bit[cyc] = ser_bit1; h1_rv[cyc] = result_valid1;
        h1_d3[cyc] = (r13 == 0);
        r3  = ser_rst  ? 0 : (r3 * 2 + int'(ser_bit)) % 3;
        r5  = ser_rst  ? 0 : (r5 * 2 + int'(ser_bit)) % 5;
        r13 = ser_rst1 ? 0 : (r13 * 2 + int'(ser_bit1)) % 3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a, b, c, d, e, f, bits, rv_cnt;
        repeat (2) step();
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_busy", int'(busy), 0);
        repeat (2) step();

        // Word 15, with an ignored 0xFF offered mid-shift
        a = cyc; in_valid = 1'b1; in_data = 8'd15; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'hFF; step(); step();
        in_valid = 1'b0; repeat (8) step();
        bits = 0;
        for (int i = 0; i < W; i++) bits = bits * 2 + int'(h_bit[a + 2 + i]);
        chk("w15_ser_rst", int'(h_rst[a + 1]), 1);
        chk("w15_bits", bits, 15);
        chk("w15_rv", int'(h_rv[a + 10]), 1);
        chk("w15_rv_early", int'(h_rv[a + 9]), 0);
        chk("w15_div3", int'(h_d3[a + 10]), 1);
        chk("w15_div5", int'(h_d5[a + 10]), 1);
        chk("w15_ready_during_ff", int'(h_ready[a + 4]), 0);

        // Back-to-back 7 then 10 with in_valid held high
        b = cyc; in_valid = 1'b1; in_data = 8'd7; step();
        in_data = 8'd10; repeat (10) step();
        in_valid = 1'b0; repeat (11) step();
        chk("b2b_rv1", int'(h_rv[b + 10]), 1);
        chk("b2b_div3_1", int'(h_d3[b + 10]), 0);
        chk("b2b_div5_1", int'(h_d5[b + 10]), 0);
        chk("b2b_rv2", int'(h_rv[b + 20]), 1);
        chk("b2b_div3_2", int'(h_d3[b + 20]), 0);
        chk("b2b_div5_2", int'(h_d5[b + 20]), 1);
        chk("b2b_ready_shift", int'(h_ready[b + 5]), 0);
        chk("b2b_ready_done", int'(h_ready[b + 10]), 1);

        // Flush 255 in its 4th shift cycle, then 5
        c = cyc; in_valid = 1'b1; in_data = 8'd255; step();
        in_valid = 1'b0; repeat (4) step();
        flush = 1'b1; step();
        flush = 1'b0; step(); step();
        e = cyc; in_valid = 1'b1; in_data = 8'd5; step();
        in_valid = 1'b0; repeat (11) step();
        rv_cnt = 0;
        for (int k = c + 6; k < e + 10; k++) rv_cnt += int'(h_rv[k]);
        chk("flush_idle_ready", int'(h_ready[c + 6]), 1);
        chk("flush_no_rv", rv_cnt, 0);
        chk("after_flush_rv", int'(h_rv[e + 10]), 1);
        chk("after_flush_div5", int'(h_d5[e + 10]), 1);
        chk("after_flush_div3", int'(h_d3[e + 10]), 0);

        // rst during CLEAR, then word 3
        d = cyc; in_valid = 1'b1; in_data = 8'hA5; step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0; step();
        in_valid = 1'b1; in_data = 8'd3; step();
        in_valid = 1'b0; repeat (11) step();
        chk("rst_clear_ready", int'(h_ready[d + 2]), 1);
        chk("rst_clear_busy", int'(h_busy[d + 2]), 0);
        chk("rst_clear_ser_rst", int'(h_rst[d + 2]), 0);
        chk("rst_clear_rv", int'(h_rv[d + 2]) + int'(h_rv[d + 10]), 0);
        chk("after_rst_rv", int'(h_rv[d + 13]), 1);
        chk("after_rst_div3", int'(h_d3[d + 13]), 1);

        // WIDTH=1 instance
        f = cyc; in_valid1 = 1'b1; in_data1 = 1'b1; step();
        in_valid1 = 1'b0; repeat (4) step();
        chk("w1_ser_rst", int'(h1_rst[f + 1]), 1);
        chk("w1_ser_bit", int'(h1_bit[f + 2]), 1);
        chk("w1_rv_early", int'(h1_rv[f + 2]), 0);
        chk("w1_rv", int'(h1_rv[f + 3]), 1);
        chk("w1_div3", int'(h1_d3[f + 3]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
